// File: rtl/pipeline_hazard_unit.sv
// Hazard controller for the 5-stage pipeline: EX operand forwarding, load-use bubbles,
// data-memory freeze with timeout, branch flushes, and saturating stall/flush counters.
module pipeline_hazard_unit #(
   parameter int unsigned XLEN        = 64,
   parameter int unsigned NREG        = 32,
   parameter int unsigned RA_W        = $clog2(NREG),
   parameter int unsigned BR_STAGE    = 3,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [RA_W-1:0]  ex_rs1,
   input  logic [RA_W-1:0]  ex_rs2,
   input  logic [XLEN-1:0]  ex_rs1_data,
   input  logic [XLEN-1:0]  ex_rs2_data,
   input  logic [RA_W-1:0]  ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_reg_write,
   input  logic [RA_W-1:0]  mem_rd,
   input  logic             mem_reg_write,
   input  logic [XLEN-1:0]  mem_alu_result,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic [RA_W-1:0]  wb_rd,
   input  logic             wb_reg_write,
   input  logic [XLEN-1:0]  wb_data,
   input  logic             branch_taken,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_write,
   output logic             exmem_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_bubble,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic [XLEN-1:0]  ex_op_a,
   output logic [XLEN-1:0]  ex_op_b,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic             mem_timeout
);

   localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_ERROR} state_e;

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [CNT_W-1:0]   stall_q, flush_q;
   logic               freeze, load_use, stall_evt, flush_evt;

   // ex_reg_write is implied by ex_mem_read for loads; kept on the port for drop-in wiring.
   logic unused_ex_reg_write;
   assign unused_ex_reg_write = ex_reg_write;

   function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] r);
      if (mem_reg_write && mem_rd == r && r != '0)    return 2'b10;
      else if (wb_reg_write && wb_rd == r && r != '0) return 2'b01;
      else                                             return 2'b00;
   endfunction

   always_comb begin
      fwd_a_sel = '0;
      fwd_b_sel = '0;
      if (!rst) begin
         fwd_a_sel = fwd_sel(ex_rs1);
         fwd_b_sel = fwd_sel(ex_rs2);
      end
      case (fwd_a_sel)
         2'b10:   ex_op_a = mem_alu_result;
         2'b01:   ex_op_a = wb_data;
         default: ex_op_a = ex_rs1_data;
      endcase
      case (fwd_b_sel)
         2'b10:   ex_op_b = mem_alu_result;
         2'b01:   ex_op_b = wb_data;
         default: ex_op_b = ex_rs2_data;
      endcase
   end

   assign freeze   = mem_req && !mem_ready;
   assign load_use = ex_mem_read && ex_rd != '0 &&
                     ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));

   always_comb begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_flush  = 1'b0;
      memwb_bubble = 1'b0;
      stall_evt    = 1'b0;
      flush_evt    = 1'b0;
      state_d      = state_q;
      wait_d       = wait_q;
      if (rst) begin
         state_d = S_RUN;
         wait_d  = '0;
      end else if (state_q == S_ERROR) begin
         memwb_bubble = 1'b1;
      end else if (freeze) begin
         // wait_q counts frozen cycles already completed, including the one seen in RUN
         memwb_bubble = 1'b1;
         stall_evt    = 1'b1;
         if (wait_q >= WAIT_LAST) begin
            state_d = S_ERROR;
         end else begin
            state_d = S_MEM_WAIT;
            wait_d  = wait_q + 1'b1;
         end
      end else begin
         state_d     = S_RUN;
         wait_d      = '0;
         pc_write    = 1'b1;
         ifid_write  = 1'b1;
         idex_write  = 1'b1;
         exmem_write = 1'b1;
         if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = (BR_STAGE == 3);
            flush_evt   = 1'b1;
         end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            stall_evt  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_RUN;
         wait_q  <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (stall_evt && stall_q != '1) stall_q <= stall_q + 1'b1;
         if (flush_evt && flush_q != '1) flush_q <= flush_q + 1'b1;
      end
   end

   assign stall_count = stall_q;
   assign flush_count = flush_q;
   assign mem_timeout = (state_q == S_ERROR);

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench for pipeline_hazard_unit (BR_STAGE=3, MEM_TIMEOUT=8): vector table
// for forwarding/priority, then hand-written load-use, branch, freeze and timeout sequences.
module tb_pipeline_hazard_unit;

   localparam logic [7:0] C_RUN = 8'hF0; // {pc,ifid,idex,exmem writes, ifid,idex,exmem flush, bubble}
   localparam logic [7:0] C_LU  = 8'h34;
   localparam logic [7:0] C_BR  = 8'hFE;
   localparam logic [7:0] C_FZ  = 8'h01;
   localparam logic [63:0] RS1D = 64'h1111, RS2D = 64'h2222, ALUD = 64'hAA, WBD = 64'hBB;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_reg_write, mem_reg_write;
   logic        mem_req, mem_ready, wb_reg_write, branch_taken;
   logic [63:0] ex_rs1_data, ex_rs2_data, mem_alu_result, wb_data, ex_op_a, ex_op_b;
   logic        pc_write, ifid_write, idex_write, exmem_write;
   logic        ifid_flush, idex_flush, exmem_flush, memwb_bubble, mem_timeout;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic [31:0] stall_count, flush_count;

   pipeline_hazard_unit #(.XLEN(64), .NREG(32), .BR_STAGE(3), .CNT_W(32), .MEM_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_alu_result(mem_alu_result),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
      .branch_taken(branch_taken),
      .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write), .exmem_write(exmem_write),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
      .memwb_bubble(memwb_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .stall_count(stall_count), .flush_count(flush_count),
      .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      int rs1, rs2, mrd, mrw, wrd, wrw, exmr, exrd, idrs1, u1, idrs2, u2, mreq, mrdy, br;
      logic [1:0] sa, sb;
      logic [7:0] ctrl;
   } vec_t;

   typedef struct {
      string name;
      logic [1:0]  sa, sb;
      logic [63:0] oa, ob;
      logic [7:0]  ctrl;
   } exp_t;

   vec_t vt[14];
   exp_t sbq[$];
   int total = 0;
   int bad = 0;

   function automatic vec_t mk(string n, int rs1, int rs2, int mrd, int mrw, int wrd, int wrw,
                               int exmr, int exrd, int idrs1, int u1, int idrs2, int u2,
                               int mreq, int mrdy, int br, logic [1:0] sa, logic [1:0] sb,
                               logic [7:0] ctrl);
      vec_t v;
      v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.mrd = mrd; v.mrw = mrw; v.wrd = wrd; v.wrw = wrw;
      v.exmr = exmr; v.exrd = exrd; v.idrs1 = idrs1; v.u1 = u1; v.idrs2 = idrs2; v.u2 = u2;
      v.mreq = mreq; v.mrdy = mrdy; v.br = br; v.sa = sa; v.sb = sb; v.ctrl = ctrl;
      return v;
   endfunction

   function automatic logic [63:0] op_for(logic [1:0] sel, logic [63:0] rf);
      case (sel)
         2'b10:   return ALUD;
         2'b01:   return WBD;
         default: return rf;
      endcase
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic push_exp(string nm, logic [1:0] sa, logic [1:0] sb, logic [7:0] ctrl);
      exp_t e;
      e.name = nm; e.sa = sa; e.sb = sb; e.ctrl = ctrl;
      e.oa = op_for(sa, RS1D);
      e.ob = op_for(sb, RS2D);
      sbq.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      e = sbq.pop_front();
      chk({e.name, ".ctrl"}, 64'({pc_write, ifid_write, idex_write, exmem_write,
                                  ifid_flush, idex_flush, exmem_flush, memwb_bubble}), 64'(e.ctrl));
      chk({e.name, ".sel_a"}, 64'(fwd_a_sel), 64'(e.sa));
      chk({e.name, ".sel_b"}, 64'(fwd_b_sel), 64'(e.sb));
      chk({e.name, ".op_a"}, ex_op_a, e.oa);
      chk({e.name, ".op_b"}, ex_op_b, e.ob);
   endtask

   task automatic idle();
      id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_mem_read = 0; ex_reg_write = 0;
      mem_rd = '0; mem_reg_write = 0; mem_req = 0; mem_ready = 0;
      wb_rd = '0; wb_reg_write = 0; branch_taken = 0;
   endtask

   task automatic apply(vec_t v);
      ex_rs1 = 5'(v.rs1); ex_rs2 = 5'(v.rs2);
      mem_rd = 5'(v.mrd); mem_reg_write = 1'(v.mrw);
      wb_rd = 5'(v.wrd); wb_reg_write = 1'(v.wrw);
      ex_mem_read = 1'(v.exmr); ex_reg_write = 1'(v.exmr); ex_rd = 5'(v.exrd);
      id_rs1 = 5'(v.idrs1); id_uses_rs1 = 1'(v.u1);
      id_rs2 = 5'(v.idrs2); id_uses_rs2 = 1'(v.u2);
      mem_req = 1'(v.mreq); mem_ready = 1'(v.mrdy); branch_taken = 1'(v.br);
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst = 1'b1;
      #1 rst = 1'b0;
   endtask

   task automatic step_ctrl(string nm, logic [7:0] ctrl);
      #2;
      push_exp(nm, 2'b00, 2'b00, ctrl);
      check_out();
   endtask

   initial begin
      ex_rs1_data = RS1D; ex_rs2_data = RS2D; mem_alu_result = ALUD; wb_data = WBD;
      //              name            rs1 rs2 mrd mrw wrd wrw exmr exrd idrs1 u1 idrs2 u2 mreq mrdy br  sa     sb     ctrl
      vt[0]  = mk("fwd_pri",       5,  7,  5,  1,  5,  1,  0,   0,  0,    0, 0,    0, 0,   0,   0, 2'b10, 2'b00, C_RUN);
      vt[1]  = mk("fwd_x0",        0,  0,  0,  1,  0,  1,  0,   0,  0,    0, 0,    0, 0,   0,   0, 2'b00, 2'b00, C_RUN);
      vt[2]  = mk("fwd_wb",        1,  9,  9,  0,  9,  1,  0,   0,  0,    0, 0,    0, 0,   0,   0, 2'b00, 2'b01, C_RUN);
      vt[3]  = mk("fwd_split",     4,  6,  6,  1,  4,  1,  0,   0,  0,    0, 0,    0, 0,   0,   0, 2'b01, 2'b10, C_RUN);
      vt[4]  = mk("fwd_both",      3,  3,  3,  1,  0,  0,  0,   0,  0,    0, 0,    0, 0,   0,   0, 2'b10, 2'b10, C_RUN);
      vt[5]  = mk("lu_rs2",        0,  0,  0,  0,  0,  0,  1,   3,  3,    0, 3,    1, 0,   0,   0, 2'b00, 2'b00, C_LU);
      vt[6]  = mk("lu_unused",     0,  0,  0,  0,  0,  0,  1,   3,  3,    0, 3,    0, 0,   0,   0, 2'b00, 2'b00, C_RUN);
      vt[7]  = mk("lu_x0",         0,  0,  0,  0,  0,  0,  1,   0,  0,    1, 0,    1, 0,   0,   0, 2'b00, 2'b00, C_RUN);
      vt[8]  = mk("lu_rs1",        0,  0,  0,  0,  0,  0,  1,  12, 12,    1, 0,    0, 0,   0,   0, 2'b00, 2'b00, C_LU);
      vt[9]  = mk("lu_noload",     0,  0,  0,  0,  0,  0,  0,  12, 12,    1, 0,    0, 0,   0,   0, 2'b00, 2'b00, C_RUN);
      vt[10] = mk("br_over_lu",    0,  0,  0,  0,  0,  0,  1,  12, 12,    1, 0,    0, 0,   0,   1, 2'b00, 2'b00, C_BR);
      vt[11] = mk("frz_over_br",   0,  0,  0,  0,  0,  0,  1,  12, 12,    1, 0,    0, 1,   0,   1, 2'b00, 2'b00, C_FZ);
      vt[12] = mk("ready_is_run",  0,  0,  0,  0,  0,  0,  0,   0,  0,    0, 0,    0, 1,   1,   1, 2'b00, 2'b00, C_BR);
      vt[13] = mk("noreq",         0,  0,  0,  0,  0,  0,  0,   0,  0,    0, 0,    0, 0,   0,   0, 2'b00, 2'b00, C_RUN);

      // reset: hazards present on inputs but all controls must be quiet
      #1;
      apply(vt[0]);
      branch_taken = 1; ex_mem_read = 1; ex_rd = 3; id_rs2 = 3; id_uses_rs2 = 1;
      rst = 1'b1;
      #2;
      push_exp("reset", 2'b00, 2'b00, 8'h00);
      check_out();
      chk("reset.stall_count", 64'(stall_count), 64'd0);
      chk("reset.flush_count", 64'(flush_count), 64'd0);
      chk("reset.mem_timeout", 64'(mem_timeout), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         apply(vt[i]);
         push_exp(vt[i].name, vt[i].sa, vt[i].sb, vt[i].ctrl);
         #2;
         check_out();
      end

      // load-use: exactly one stall cycle
      do_reset();
      @(negedge clk);
      ex_mem_read = 1; ex_rd = 3; id_rs2 = 3; id_uses_rs2 = 1;
      step_ctrl("seq_lu.stall", C_LU);
      @(negedge clk);
      idle();
      step_ctrl("seq_lu.resume", C_RUN);
      chk("seq_lu.stall_count", 64'(stall_count), 64'd1);
      chk("seq_lu.flush_count", 64'(flush_count), 64'd0);

      // branch with concurrent load-use
      do_reset();
      @(negedge clk);
      branch_taken = 1; ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1;
      step_ctrl("seq_br.flush", C_BR);
      @(negedge clk);
      idle();
      step_ctrl("seq_br.after", C_RUN);
      chk("seq_br.flush_count", 64'(flush_count), 64'd1);
      chk("seq_br.stall_count", 64'(stall_count), 64'd0);

      // 4-cycle memory wait with a branch held in MEM; flushed once unfrozen
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mem_req = 1; mem_ready = 0; branch_taken = 1;
         step_ctrl($sformatf("seq_mw.frz%0d", i), C_FZ);
      end
      @(negedge clk);
      mem_ready = 1;
      step_ctrl("seq_mw.ready", C_BR);
      @(negedge clk);
      idle();
      step_ctrl("seq_mw.run", C_RUN);
      chk("seq_mw.stall_count", 64'(stall_count), 64'd4);
      chk("seq_mw.flush_count", 64'(flush_count), 64'd1);
      chk("seq_mw.mem_timeout", 64'(mem_timeout), 64'd0);

      // rst mid-wait returns to RUN
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_req = 1; mem_ready = 0;
      end
      #2 rst = 1'b1;
      #1 rst = 1'b0;
      chk("seq_rmw.stall_count", 64'(stall_count), 64'd0);
      @(negedge clk);
      idle();
      step_ctrl("seq_rmw.run", C_RUN);

      // timeout after 8 frozen cycles, sticky until rst
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         mem_req = 1; mem_ready = 0;
         step_ctrl($sformatf("seq_to.frz%0d", i), C_FZ);
         chk($sformatf("seq_to.pre_timeout%0d", i), 64'(mem_timeout), 64'd0);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         step_ctrl($sformatf("seq_to.err%0d", i), C_FZ);
         chk($sformatf("seq_to.timeout%0d", i), 64'(mem_timeout), 64'd1);
      end
      chk("seq_to.stall_count", 64'(stall_count), 64'd8);
      @(negedge clk);
      mem_req = 0; mem_ready = 1; branch_taken = 1;
      step_ctrl("seq_to.sticky", C_FZ);
      chk("seq_to.sticky_timeout", 64'(mem_timeout), 64'd1);
      chk("seq_to.no_flush_count", 64'(flush_count), 64'd0);
      rst = 1'b1;
      #1;
      chk("seq_to.rst_timeout", 64'(mem_timeout), 64'd0);
      chk("seq_to.rst_stall", 64'(stall_count), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      idle();
      step_ctrl("seq_to.run_after_rst", C_RUN);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
